// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   div_state_t    : IDLE / RUN / DONE control states
//   cnt_width()    : width of the step counter for a WIDTH / BITS_PER_CYCLE pair
//   params_legal() : elaboration-time parameter check
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Counter must hold WIDTH/BITS_PER_CYCLE itself, hence the +1.
   function automatic int cnt_width(input int width, input int bpc);
      return $clog2(width / bpc + 1);
   endfunction

   function automatic bit params_legal(input int width, input int bpc);
      return (width >= 2) && (width <= 32) &&
             ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
             ((width % bpc) == 0);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   a       : partial remainder A (WIDTH+1 bits)
//   divisor : divisor (WIDTH bits)
//   bit_in  : next dividend bit shifted into A
//   a_next  : partial remainder after shift and conditional subtract
//   q_bit   : quotient bit produced by this step
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] divisor,
   input  logic             bit_in,
   output logic [WIDTH:0]   a_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           unused_msb;

   // A < divisor between steps, so its MSB is always 0 and drops out of the shift.
   assign unused_msb = a[WIDTH];

   assign shifted = {a[WIDTH-1:0], bit_in};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = (shifted >= {1'b0, divisor});
   assign a_next  = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_unsigned_divider.sv
// Multi-cycle restoring unsigned divider with valid/ready handshakes.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (accepted only in IDLE)
//   dividend, divisor  : operands, sampled on the input handshake
//   out_valid/out_ready: result handshake (result held until taken)
//   quotient, remainder: result; all ones for both on a zero divisor
//   div_by_zero        : result came from a zero divisor
//   busy               : division in RUN or waiting in DONE
module seq_unsigned_divider
   import div_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CW    = cnt_width(WIDTH, BITS_PER_CYCLE);

   if (!params_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
      $error("seq_unsigned_divider: illegal WIDTH/BITS_PER_CYCLE combination");
   end

   div_state_t state, state_nxt;

   logic [WIDTH:0]          a_q;
   logic [WIDTH-1:0]        dvd_q;
   logic [WIDTH-1:0]        dvs_q;
   logic [WIDTH-1:0]        quo_q;
   logic [WIDTH-1:0]        rem_q;
   logic                    dbz_q;
   logic [CW-1:0]           cnt_q;
   logic [BITS_PER_CYCLE-1:0] q_bits;
   logic [WIDTH:0]          a_final;
   logic                    accept;
   logic                    last_step;

   assign accept    = in_valid && (state == IDLE);
   assign last_step = (state == RUN) && (cnt_q == CW'(1));

   // Chain of restoring steps; step k consumes dividend bit WIDTH-1-k and
   // yields quotient bit BITS_PER_CYCLE-1-k, so the first step is most significant.
   for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
      logic [WIDTH:0] a_in;
      logic [WIDTH:0] a_out;
      logic           q_bit;

      if (k == 0) begin : g_first
         assign a_in = a_q;
      end else begin : g_chain
         assign a_in = g_step[k-1].a_out;
      end

      div_step #(.WIDTH(WIDTH)) u_step (
         .a      (a_in),
         .divisor(dvs_q),
         .bit_in (dvd_q[WIDTH-1-k]),
         .a_next (a_out),
         .q_bit  (q_bit)
      );

      assign q_bits[BITS_PER_CYCLE-1-k] = q_bit;
   end

   assign a_final = g_step[BITS_PER_CYCLE-1].a_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         dvd_q <= '0;
         dvs_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
         cnt_q <= '0;
      end else if (accept) begin
         dvd_q <= dividend;
         dvs_q <= divisor;
         a_q   <= '0;
         if (divisor == '0) begin
            quo_q <= '1;
            rem_q <= '1;
            dbz_q <= 1'b1;
            cnt_q <= '0;
         end else begin
            quo_q <= '0;
            dbz_q <= 1'b0;
            cnt_q <= CW'(STEPS);
         end
      end else if (state == RUN) begin
         a_q   <= a_final;
         dvd_q <= dvd_q << BITS_PER_CYCLE;
         quo_q <= (quo_q << BITS_PER_CYCLE) | WIDTH'(q_bits);
         cnt_q <= cnt_q - CW'(1);
         if (last_step) begin
            rem_q <= a_final[WIDTH-1:0];
         end
      end
   end

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
module tb_seq_unsigned_divider;

   typedef struct {
      longint q;
      longint r;
      bit     dbz;
      longint lat;
      longint acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // 8-bit, 1 bit per cycle
   logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
   logic [7:0]  dividend8 = '0, divisor8 = '0, quotient8, remainder8;
   logic        dbz8, busy8;
   // 16-bit, 4 bits per cycle
   logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
   logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;
   logic        dbz16, busy16;

   int or_mode8  = 0;   // 0: always ready, 1: random, 2: driven by the main sequence
   int or_mode16 = 0;

   exp_t sb8[$];
   exp_t sb16[$];

   seq_unsigned_divider #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .dividend(dividend8), .divisor(divisor8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .quotient(quotient8), .remainder(remainder8),
      .div_by_zero(dbz8), .busy(busy8)
   );

   seq_unsigned_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .dividend(dividend16), .divisor(divisor16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .quotient(quotient16), .remainder(remainder16),
      .div_by_zero(dbz16), .busy(busy16)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      checks++;
      errors++;
      $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
   endtask

   function automatic exp_t mk(input longint q, input longint r, input bit dbz, input longint lat);
      exp_t e;
      e.q = q; e.r = r; e.dbz = dbz; e.lat = lat; e.acc = 0;
      return e;
   endfunction

   // Reference: plain integer division; zero divisor gives all ones, flagged,
   // and the result appears straight after the accept edge.
   function automatic exp_t model(input longint a, input longint b, input int width, input int bpc);
      if (b == 0) return mk((64'd1 << width) - 1, (64'd1 << width) - 1, 1'b1, 0);
      return mk(a / b, a % b, 1'b0, width / bpc);
   endfunction

   always @(posedge clk) begin
      #1;
      if (or_mode8 == 0) out_ready8 = 1'b1;
      else if (or_mode8 == 1) out_ready8 = 1'($urandom_range(0, 1));
      if (or_mode16 == 0) out_ready16 = 1'b1;
      else if (or_mode16 == 1) out_ready16 = 1'($urandom_range(0, 1));
   end

   // Monitors: compare whatever the DUT presents against the head of its queue.
   logic ov_prev8 = 1'b0;
   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst) begin
         ov_prev8 = 1'b0;
      end else begin
         chk("busy8_vs_in_ready8", busy8, !in_ready8);
         if (out_valid8) begin
            if (sb8.size() == 0) begin
               fail_now("unexpected8", "out_valid with empty scoreboard");
            end else begin
               e = sb8[0];
               if (!ov_prev8) begin
                  chk("latency8", cyc - e.acc, e.lat);
                  chk("in_ready8_in_done", in_ready8, 0);
               end
               chk("quotient8", quotient8, e.q);
               chk("remainder8", remainder8, e.r);
               chk("dbz8", dbz8, e.dbz);
               if (out_ready8) void'(sb8.pop_front());
            end
         end
         ov_prev8 = out_valid8;
      end
   end

   logic ov_prev16 = 1'b0;
   always @(negedge clk) begin : mon16
      exp_t e;
      if (rst) begin
         ov_prev16 = 1'b0;
      end else if (out_valid16) begin
         if (sb16.size() == 0) begin
            fail_now("unexpected16", "out_valid with empty scoreboard");
         end else begin
            e = sb16[0];
            if (!ov_prev16) chk("latency16", cyc - e.acc, e.lat);
            chk("quotient16", quotient16, e.q);
            chk("remainder16", remainder16, e.r);
            chk("dbz16", dbz16, e.dbz);
            if (out_ready16) void'(sb16.pop_front());
         end
         ov_prev16 = 1'b1;
      end else begin
         ov_prev16 = 1'b0;
      end
   end

   // Drivers: called just after a rising edge; return just after the accept edge.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
      bit acc = 1'b0;
      int unsigned budget = 0;
      dividend8 = a; divisor8 = b; in_valid8 = 1'b1;
      while (!acc && budget < 300) begin
         @(negedge clk);
         acc = in_ready8;
         budget++;
         @(posedge clk);
         #1;
      end
      in_valid8 = 1'b0;
      if (acc) begin
         e.acc = cyc;
         sb8.push_back(e);
      end else begin
         fail_now("accept_timeout8", "in_ready never rose");
      end
      // Operands in flight must not follow the input pins.
      dividend8 = 8'($urandom); divisor8 = 8'($urandom);
   endtask

   task automatic send16(input logic [15:0] a, input logic [15:0] b, input exp_t e);
      bit acc = 1'b0;
      int unsigned budget = 0;
      dividend16 = a; divisor16 = b; in_valid16 = 1'b1;
      while (!acc && budget < 300) begin
         @(negedge clk);
         acc = in_ready16;
         budget++;
         @(posedge clk);
         #1;
      end
      in_valid16 = 1'b0;
      if (acc) begin
         e.acc = cyc;
         sb16.push_back(e);
      end else begin
         fail_now("accept_timeout16", "in_ready never rose");
      end
      dividend16 = 16'($urandom); divisor16 = 16'($urandom);
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned n = 0;
      while ((sb8.size() != 0 || sb16.size() != 0) && n < limit) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb8.size() != 0 || sb16.size() != 0) fail_now("drain_timeout", "results still outstanding");
   endtask

   task automatic random8(input int n);
      logic [7:0] a, b;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         a = 8'($urandom);
         case ($urandom_range(0, 9))
            0: b = 8'd0;
            1: b = 8'd1;
            2: b = a;
            3: b = 8'hFF;
            4: b = 8'($urandom_range(1, 15));
            default: b = 8'($urandom);
         endcase
         send8(a, b, model(a, b, 8, 1));
      end
   endtask

   task automatic random16(input int n);
      logic [15:0] a, b;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         a = 16'($urandom);
         case ($urandom_range(0, 7))
            0: b = 16'd0;
            1: b = 16'd1;
            2: b = 16'hFFFF;
            3: b = 16'($urandom_range(1, 300));
            default: b = 16'($urandom);
         endcase
         send16(a, b, model(a, b, 16, 4));
      end
   endtask

   initial begin : main
      int unsigned n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready8", in_ready8, 1);
      chk("rst_out_valid8", out_valid8, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_quotient8", quotient8, 0);
      chk("rst_remainder8", remainder8, 0);
      chk("rst_dbz8", dbz8, 0);
      chk("rst_in_ready16", in_ready16, 1);
      chk("rst_quotient16", quotient16, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases, consumer always ready.
      send8(8'd200, 8'd7,   mk(28, 4, 0, 8));
      send8(8'd5,   8'd9,   mk(0, 5, 0, 8));
      send8(8'd255, 8'd1,   mk(255, 0, 0, 8));
      send8(8'd255, 8'd255, mk(1, 0, 0, 8));
      send8(8'd13,  8'd0,   mk(255, 255, 1, 0));
      drain(100);

      // Backpressure: result held for five cycles, then taken.
      @(posedge clk);
      #1;
      or_mode8 = 2;
      out_ready8 = 1'b0;
      send8(8'd200, 8'd7, mk(28, 4, 0, 8));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid8 && n < 50);
      if (!out_valid8) fail_now("bp_wait", "out_valid never rose");
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready8", in_ready8, 0);
         chk("bp_quotient8", quotient8, 28);
         chk("bp_remainder8", remainder8, 4);
      end
      @(posedge clk);
      #1;
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_in_ready8", in_ready8, 1);
      chk("bp_idle_out_valid8", out_valid8, 0);
      or_mode8 = 0;

      // Reset in the middle of a division.
      send8(8'd100, 8'd3, mk(33, 1, 0, 8));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid8", out_valid8, 0);
      chk("midrst_in_ready8", in_ready8, 1);
      chk("midrst_quotient8", quotient8, 0);
      chk("midrst_busy8", busy8, 0);
      sb8.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send8(8'd9, 8'd2, mk(4, 1, 0, 8));
      drain(100);

      // Wider, four bits per cycle.
      send16(16'd60000, 16'd123, mk(487, 99, 0, 4));
      drain(100);

      // Random sweep with input gaps and random backpressure on both instances.
      or_mode8 = 1;
      or_mode16 = 1;
      fork
         random8(1000);
         random16(400);
      join
      drain(500);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
